// File: rtl/mem_stage_unit_pkg.sv
// Shared encodings for the memory stage: stack-op codes, FSM states and SP reset value.
package mem_pkg;

    localparam logic [7:0] SP_INIT_DEFAULT = 8'hFF;

    localparam logic [1:0] SP_PUSH = 2'b00;
    localparam logic [1:0] SP_POP  = 2'b01;
    localparam logic [1:0] SP_LOAD = 2'b10;
    localparam logic [1:0] SP_NONE = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_stage_unit_io_in_sync.sv
// Two-flop synchroniser bringing the asynchronous input port into the clk domain.
module io_in_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_d,
    output logic [7:0] o_q
);

    logic [7:0] r_meta;
    logic [7:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/mem_stage_unit.sv
// Memory stage: data-memory req/ack access, stack pointer, I/O port registers and MEM/WB register.
module mem_stage_unit
    import mem_pkg::*;
#(
    parameter logic [7:0] SP_INIT = SP_INIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ex_wb_reg_write,
    input  logic [7:0] ex_alu_result,
    input  logic [1:0] ex_write_addr,
    input  logic [3:0] ex_flags,
    input  logic       ex_update_flags,
    input  logic       ex_mem_write,
    input  logic       ex_mem_to_reg,
    input  logic       ex_io_read,
    input  logic       ex_io_write,
    input  logic       ex_sp_update,
    input  logic [1:0] ex_sp_op,
    input  logic [7:0] ex_store_data,
    input  logic       ex_is_ret,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic [7:0] dmem_addr,
    output logic [7:0] dmem_wdata,
    input  logic [7:0] dmem_rdata,
    input  logic       dmem_ack,
    input  logic [7:0] in_port,
    output logic [7:0] out_port,
    output logic       mem_stall,
    output logic       wb_reg_write,
    output logic [7:0] wb_data,
    output logic [1:0] wb_write_addr,
    output logic [3:0] wb_flags,
    output logic       wb_update_flags,
    output logic       ret_valid,
    output logic [7:0] ret_pc
);

    mem_state_t r_state;
    logic [7:0] r_sp;
    logic [7:0] r_out_port;
    logic       r_dmem_req;
    logic       r_dmem_we;
    logic [7:0] r_dmem_addr;
    logic [7:0] r_dmem_wdata;
    logic       r_wb_reg_write;
    logic [7:0] r_wb_data;
    logic [1:0] r_wb_write_addr;
    logic [3:0] r_wb_flags;
    logic       r_wb_update_flags;
    logic       r_ret_valid;
    logic [7:0] r_ret_pc;

    logic       w_is_push;
    logic       w_is_pop;
    logic       w_is_sp_load;
    logic       w_is_read;
    logic       w_is_ret;
    logic       w_mem_op;
    logic       w_stall;
    logic       w_ack;
    logic [7:0] w_addr;
    logic [7:0] w_in_sync;

    io_in_sync u_in_sync (
        .clk (clk),
        .rst (rst),
        .i_d (in_port),
        .o_q (w_in_sync)
    );

    assign w_is_push    = ex_sp_update && (ex_sp_op == SP_PUSH);
    assign w_is_pop     = ex_sp_update && (ex_sp_op == SP_POP);
    assign w_is_sp_load = ex_sp_update && (ex_sp_op == SP_LOAD);
    assign w_mem_op     = ex_mem_write || ex_mem_to_reg || w_is_push || w_is_pop;
    // A store takes precedence over a load flagged on the same instruction.
    assign w_is_read    = w_is_pop || (ex_mem_to_reg && !ex_mem_write && !w_is_push);
    assign w_is_ret     = w_is_pop && ex_is_ret;
    assign w_addr       = w_is_push ? r_sp : (w_is_pop ? r_sp + 8'd1 : ex_alu_result);
    assign w_ack        = (r_state == ST_ACCESS) && dmem_ack;
    assign w_stall      = ((r_state == ST_IDLE) && w_mem_op) || ((r_state == ST_ACCESS) && !dmem_ack);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_sp         <= SP_INIT;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_mem_op) begin
                        r_state      <= ST_ACCESS;
                        r_dmem_req   <= 1'b1;
                        r_dmem_we    <= ex_mem_write || w_is_push;
                        r_dmem_addr  <= w_addr;
                        r_dmem_wdata <= ex_store_data;
                    end else if (w_is_sp_load) begin
                        r_sp <= ex_alu_result;
                    end
                end
                ST_ACCESS: begin
                    if (dmem_ack) begin
                        r_state    <= ST_IDLE;
                        r_dmem_req <= 1'b0;
                        if (w_is_push) r_sp <= r_sp - 8'd1;
                        else if (w_is_pop) r_sp <= r_sp + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Stalled cycles insert a bubble: only the qualifying strobes are cleared, data fields hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_port        <= '0;
            r_wb_reg_write    <= 1'b0;
            r_wb_data         <= '0;
            r_wb_write_addr   <= '0;
            r_wb_flags        <= '0;
            r_wb_update_flags <= 1'b0;
            r_ret_valid       <= 1'b0;
            r_ret_pc          <= '0;
        end else if (w_stall) begin
            r_wb_reg_write    <= 1'b0;
            r_wb_update_flags <= 1'b0;
            r_ret_valid       <= 1'b0;
        end else begin
            if (ex_io_write) r_out_port <= ex_store_data;
            r_wb_reg_write    <= ex_wb_reg_write && !w_is_ret;
            r_wb_write_addr   <= ex_write_addr;
            r_wb_flags        <= ex_flags;
            r_wb_update_flags <= ex_update_flags;
            r_ret_valid       <= w_is_ret && w_ack;
            if (w_is_ret) r_ret_pc <= dmem_rdata;
            if (w_is_read) r_wb_data <= dmem_rdata;
            else if (ex_io_read) r_wb_data <= w_in_sync;
            else r_wb_data <= ex_alu_result;
        end
    end

    assign mem_stall       = w_stall;
    assign dmem_req        = r_dmem_req;
    assign dmem_we         = r_dmem_we;
    assign dmem_addr       = r_dmem_addr;
    assign dmem_wdata      = r_dmem_wdata;
    assign out_port        = r_out_port;
    assign wb_reg_write    = r_wb_reg_write;
    assign wb_data         = r_wb_data;
    assign wb_write_addr   = r_wb_write_addr;
    assign wb_flags        = r_wb_flags;
    assign wb_update_flags = r_wb_update_flags;
    assign ret_valid       = r_ret_valid;
    assign ret_pc          = r_ret_pc;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed self-checking bench for mem_stage_unit with hand-computed expectations.
module tb_mem_stage_unit;
    import mem_pkg::*;

    logic       clk;
    logic       rst;
    logic       ex_wb_reg_write;
    logic [7:0] ex_alu_result;
    logic [1:0] ex_write_addr;
    logic [3:0] ex_flags;
    logic       ex_update_flags;
    logic       ex_mem_write;
    logic       ex_mem_to_reg;
    logic       ex_io_read;
    logic       ex_io_write;
    logic       ex_sp_update;
    logic [1:0] ex_sp_op;
    logic [7:0] ex_store_data;
    logic       ex_is_ret;
    logic       dmem_req;
    logic       dmem_we;
    logic [7:0] dmem_addr;
    logic [7:0] dmem_wdata;
    logic [7:0] dmem_rdata;
    logic       dmem_ack;
    logic [7:0] in_port;
    logic [7:0] out_port;
    logic       mem_stall;
    logic       wb_reg_write;
    logic [7:0] wb_data;
    logic [1:0] wb_write_addr;
    logic [3:0] wb_flags;
    logic       wb_update_flags;
    logic       ret_valid;
    logic [7:0] ret_pc;

    int n_chk;
    int n_err;

    mem_stage_unit #(.SP_INIT(8'hFF)) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_wb_reg_write (ex_wb_reg_write),
        .ex_alu_result   (ex_alu_result),
        .ex_write_addr   (ex_write_addr),
        .ex_flags        (ex_flags),
        .ex_update_flags (ex_update_flags),
        .ex_mem_write    (ex_mem_write),
        .ex_mem_to_reg   (ex_mem_to_reg),
        .ex_io_read      (ex_io_read),
        .ex_io_write     (ex_io_write),
        .ex_sp_update    (ex_sp_update),
        .ex_sp_op        (ex_sp_op),
        .ex_store_data   (ex_store_data),
        .ex_is_ret       (ex_is_ret),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_rdata      (dmem_rdata),
        .dmem_ack        (dmem_ack),
        .in_port         (in_port),
        .out_port        (out_port),
        .mem_stall       (mem_stall),
        .wb_reg_write    (wb_reg_write),
        .wb_data         (wb_data),
        .wb_write_addr   (wb_write_addr),
        .wb_flags        (wb_flags),
        .wb_update_flags (wb_update_flags),
        .ret_valid       (ret_valid),
        .ret_pc          (ret_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_ex();
        ex_wb_reg_write = 1'b0;
        ex_alu_result   = '0;
        ex_write_addr   = '0;
        ex_flags        = '0;
        ex_update_flags = 1'b0;
        ex_mem_write    = 1'b0;
        ex_mem_to_reg   = 1'b0;
        ex_io_read      = 1'b0;
        ex_io_write     = 1'b0;
        ex_sp_update    = 1'b0;
        ex_sp_op        = SP_NONE;
        ex_store_data   = '0;
        ex_is_ret       = 1'b0;
    endtask

    // Call at a negedge with the EX/MEM inputs already driven; returns on posedge+1 after ack.
    task automatic run_access(input string tag, input int waits, input logic [7:0] rdata,
                              input logic [7:0] exp_addr, input logic exp_we,
                              input logic [7:0] exp_wdata, output int stalls, output int cycles);
        int  w;
        bit  done;
        w = 0; done = 0; stalls = 0; cycles = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (dmem_req) begin
                chk({tag, "_addr"}, 32'(dmem_addr), 32'(exp_addr));
                chk({tag, "_we"}, 32'(dmem_we), 32'(exp_we));
                if (exp_we) chk({tag, "_wdata"}, 32'(dmem_wdata), 32'(exp_wdata));
                if (w == waits) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdata;
                end else begin
                    w++;
                end
            end else if (c == 0) begin
                #1;
                chk({tag, "_stall_idle"}, 32'(mem_stall), 32'd1);
            end
            #1;
            if (mem_stall) stalls++;
            cycles++;
            @(posedge clk);
            #1;
            if (dmem_ack) begin
                dmem_ack = 1'b0;
                done = 1;
                clear_ex();
            end else begin
                chk({tag, "_bubble_wr"}, 32'(wb_reg_write), 32'd0);
                chk({tag, "_bubble_ret"}, 32'(ret_valid), 32'd0);
                @(negedge clk);
            end
        end
        if (!done) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            dmem_ack = 1'b0;
            clear_ex();
        end
    endtask

    initial begin
        int stalls;
        int cycles;
        n_chk = 0;
        n_err = 0;
        clear_ex();
        dmem_rdata = '0;
        dmem_ack   = 1'b0;
        in_port    = '0;
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_out", 32'(out_port), 32'd0);
        chk("rst_wbdata", 32'(wb_data), 32'd0);
        chk("rst_ret", 32'(ret_valid), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_sp", 32'(dut.r_sp), 32'hFF);

        // ALU op
        @(negedge clk);
        ex_alu_result = 8'h3C; ex_wb_reg_write = 1'b1; ex_write_addr = 2'd2;
        ex_flags = 4'hA; ex_update_flags = 1'b1;
        #1 chk("alu_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        chk("alu_data", 32'(wb_data), 32'h3C);
        chk("alu_waddr", 32'(wb_write_addr), 32'd2);
        chk("alu_wr", 32'(wb_reg_write), 32'd1);
        chk("alu_flags", 32'(wb_flags), 32'hA);
        chk("alu_uflags", 32'(wb_update_flags), 32'd1);
        chk("alu_sp", 32'(dut.r_sp), 32'hFF);
        clear_ex();

        // Push A5 with 3 wait cycles
        @(negedge clk);
        ex_sp_update = 1'b1; ex_sp_op = SP_PUSH; ex_store_data = 8'hA5;
        run_access("push", 3, 8'h00, 8'hFF, 1'b1, 8'hA5, stalls, cycles);
        chk("push_stalls", 32'(stalls), 32'd4);
        chk("push_sp", 32'(dut.r_sp), 32'hFE);

        // Pop, ack at N+1
        @(negedge clk);
        ex_sp_update = 1'b1; ex_sp_op = SP_POP; ex_wb_reg_write = 1'b1; ex_write_addr = 2'd1;
        run_access("pop", 0, 8'hA5, 8'hFF, 1'b0, 8'h00, stalls, cycles);
        chk("pop_cycles", 32'(cycles), 32'd2);
        chk("pop_data", 32'(wb_data), 32'hA5);
        chk("pop_wr", 32'(wb_reg_write), 32'd1);
        chk("pop_waddr", 32'(wb_write_addr), 32'd1);
        chk("pop_sp", 32'(dut.r_sp), 32'hFF);

        // RET pop: SP=FF so address wraps to 00
        @(negedge clk);
        ex_sp_update = 1'b1; ex_sp_op = SP_POP; ex_is_ret = 1'b1; ex_wb_reg_write = 1'b1;
        run_access("ret", 1, 8'h42, 8'h00, 1'b0, 8'h00, stalls, cycles);
        chk("ret_valid", 32'(ret_valid), 32'd1);
        chk("ret_pc", 32'(ret_pc), 32'h42);
        chk("ret_wr", 32'(wb_reg_write), 32'd0);
        chk("ret_sp", 32'(dut.r_sp), 32'h00);
        @(posedge clk); #1;
        chk("ret_pulse", 32'(ret_valid), 32'd0);

        // OUT then IN
        @(negedge clk);
        ex_io_write = 1'b1; ex_store_data = 8'h7E;
        in_port = 8'h19;
        @(posedge clk); #1;
        chk("out_port", 32'(out_port), 32'h7E);
        clear_ex();
        repeat (2) @(negedge clk);
        ex_io_read = 1'b1; ex_wb_reg_write = 1'b1; ex_write_addr = 2'd3; ex_alu_result = 8'h55;
        @(posedge clk); #1;
        chk("in_data", 32'(wb_data), 32'h19);
        chk("in_waddr", 32'(wb_write_addr), 32'd3);
        clear_ex();

        // Reset mid-ACCESS, then stray ack
        @(negedge clk);
        rst = 1'b1;
        #1 rst = 1'b0;
        chk("rst2_sp", 32'(dut.r_sp), 32'hFF);
        ex_sp_update = 1'b1; ex_sp_op = SP_PUSH; ex_store_data = 8'h11; ex_wb_reg_write = 1'b1;
        @(posedge clk); #1;
        chk("rst2_req_before", 32'(dmem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst2_req_drop", 32'(dmem_req), 32'd0);
        clear_ex();
        @(negedge clk);
        rst = 1'b0;
        dmem_ack = 1'b1;
        #1 chk("stray_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("stray_req", 32'(dmem_req), 32'd0);
        chk("stray_sp", 32'(dut.r_sp), 32'hFF);
        chk("stray_wr", 32'(wb_reg_write), 32'd0);

        // SP load, then push
        @(negedge clk);
        ex_sp_update = 1'b1; ex_sp_op = SP_LOAD; ex_alu_result = 8'h80;
        #1 chk("spld_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        chk("spld_sp", 32'(dut.r_sp), 32'h80);
        chk("spld_req", 32'(dmem_req), 32'd0);
        clear_ex();
        @(negedge clk);
        ex_sp_update = 1'b1; ex_sp_op = SP_PUSH; ex_store_data = 8'h33;
        run_access("push80", 1, 8'h00, 8'h80, 1'b1, 8'h33, stalls, cycles);
        chk("push80_sp", 32'(dut.r_sp), 32'h7F);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
